mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the multicycle core's memory request interface.
- Accepts one read/write request at a time from the initiator (datapath + control) and services it from an internal word RAM after a fixed, parameterised number of wait states.
- Answers with a one-cycle ready pulse plus an error flag.
- Used in place of a zero-wait memory so the control FSM's wait/ready handling can be exercised.

Parameters:
DEPTH, 256, number of 32-bit words in the internal RAM; power of two, >= 4.
WAIT_CYCLES, 2, wait states inserted between request acceptance and the access; range 0..15.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
req  in  1  request strobe; sampled only in IDLE.
wr  in  1  1 = write, 0 = read; sampled with req.
address  in  32  byte address; sampled with req.
datain  in  32  write data; sampled with req.
dataout  out  32  registered read data.
ready  out  1  one-cycle completion pulse.
busy  out  1  high while a request is in flight (WAIT or RESP).
error  out  1  valid only while ready=1; 1 = access rejected.

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - state=IDLE, wait counter=0, dataout=0, ready=0, busy=0, error=0.
  - Latched request registers cleared.
  - RAM contents are NOT cleared.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: busy=0, ready=0. On edge with req=1: latch wr/address/datain, busy rises. Go to WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0; otherwise perform the access on this same edge and go to RESP.
  - WAIT: busy=1. Counter decrements each edge. On the edge where counter==0: perform the access and go to RESP.
  - RESP: ready=1, busy=1 for exactly one cycle, then unconditionally go to IDLE.
- Latency:
  - Request sampled at edge k gives ready high in the cycle after edge k+WAIT_CYCLES.
  - That is WAIT_CYCLES+1 cycles after acceptance.
  - Minimum spacing between accepted requests is WAIT_CYCLES+2 cycles.
- req in WAIT or RESP is ignored (not queued). The initiator re-asserts req in IDLE.
- Inputs changing after acceptance have no effect; only latched copies are used.
- Access (on the edge entering RESP):
  - Word index = latched address[log2(DEPTH)+1:2].
  - Error if address[1:0]!=0 (misaligned) or address >= 4*DEPTH (out of range).
  - Read, no error: dataout <= RAM[index].
  - Write, no error: RAM[index] <= datain; dataout unchanged.
  - Error: no RAM write, dataout unchanged, error=1 during the RESP cycle.
  - error=0 in every non-RESP cycle.
- dataout holds the last successful read value until the next successful read.
- Read-after-write: a read issued after a write to the same word returns the written data. No stale bypass window exists, because the write commits before ready.
- Reset mid-transaction (WAIT or RESP):
  - Aborts to IDLE; no ready pulse is produced for the aborted request.
  - A write not yet committed (still in WAIT) is discarded.
  - A write already committed (in RESP) stays in RAM.
- reset and req both high on the same edge: reset wins; the request is not accepted.

Test Plan:
- Reset:
  - Stimulus: assert reset 2 cycles, then release.
  - Required: dataout=0, ready=0, busy=0, error=0; with req low, FSM stays IDLE and busy stays 0.
- Write/read latency (WAIT_CYCLES=2):
  - Stimulus: write 0xDEADBEEF to address 0x10, then read 0x10.
  - Required for each request: busy rises the cycle after acceptance and ready pulses exactly 3 cycles after acceptance.
  - Required for the read: dataout=0xDEADBEEF, error=0.
- Misaligned and out of range (DEPTH=256):
  - Stimulus: write to 0x13; read from 0x400.
  - Required: each gives ready with error=1; RAM[4] is unchanged; dataout keeps its prior value.
- Ignored request:
  - Stimulus: hold req=1 with a new address during WAIT and RESP.
  - Required: only the first request completes; the second is accepted only in the following IDLE cycle, and only if req is still high.
- Reset mid-write:
  - Stimulus: write 0x12345678 to 0x20; assert reset during WAIT.
  - Required: no ready pulse; a later read of 0x20 returns the old contents.
- Zero wait states (WAIT_CYCLES=0):
  - Stimulus: issue back-to-back reads to 0x0 and 0x4.
  - Required: ready one cycle after each acceptance; requests accepted every 2 cycles.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response bundle between the core's memory initiator
// and the wait-state memory responder.
interface mem_responder_if;
    logic        req;
    logic        wr;
    logic [31:0] address;
    logic [31:0] datain;
    logic [31:0] dataout;
    logic        ready;
    logic        busy;
    logic        error;

    modport master (
        output req, wr, address, datain,
        input  dataout, ready, busy, error
    );

    modport slave (
        input  req, wr, address, datain,
        output dataout, ready, busy, error
    );
endinterface

// File: rtl/mem_responder.sv
// Word RAM responder with a fixed number of wait states.
// One request in flight; completion is a one-cycle ready pulse.
module mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] dout_q;
    logic        err_q;
    logic        go;

    logic [31:0] mem [DEPTH];

    // The zero-wait path accesses straight from the bus inputs.
    logic        acc_wr;
    logic [31:0] acc_addr;
    logic [31:0] acc_data;
    logic        acc_bad;
    logic [AW-1:0] acc_idx;

    assign acc_wr   = (state == IDLE) ? bus.wr      : wr_q;
    assign acc_addr = (state == IDLE) ? bus.address : addr_q;
    assign acc_data = (state == IDLE) ? bus.datain  : data_q;
    assign acc_idx  = acc_addr[AW+1:2];
    assign acc_bad  = (acc_addr[1:0] != 2'b00) ||
                      (acc_addr[31:AW+2] != '0);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic and the access strobe.
    always_comb begin
        state_next = state;
        go         = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                        go         = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                    go         = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latch, wait counter, read data and error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= 4'd0;
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            dout_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == IDLE && bus.req) begin
                wr_q   <= bus.wr;
                addr_q <= bus.address;
                data_q <= bus.datain;
                cnt    <= CNT_INIT;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (go) begin
                err_q <= acc_bad;
                if (!acc_bad && !acc_wr) dout_q <= mem[acc_idx];
            end
        end
    end

    // RAM write port; contents survive reset, but reset blocks a commit.
    always_ff @(posedge clk) begin
        if (!reset && go && acc_wr && !acc_bad) mem[acc_idx] <= acc_data;
    end

    assign bus.dataout = dout_q;
    assign bus.ready   = (state == RESP);
    assign bus.busy    = (state != IDLE);
    assign bus.error   = (state == RESP) && err_q;
endmodule
